// File: rtl/qpsk_frame_deserializer.sv
// ---------------------------------------------------------------------------
// qpsk_frame_deserializer
//   Collects 2-bit dibits from the QPSK demodulator into FW-bit interleaved
//   frames for the deinterleaver. It aligns on start-of-frame, aborts frames
//   whose inter-symbol gap exceeds a timeout, and holds one finished frame in
//   an output register with valid/ready backpressure. A second complete frame
//   can wait in the collect register (state FULL) while the output is stalled.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous reset, active-high
//   sym_valid    in   sym_data/sym_sof valid this cycle
//   sym_data     in   demodulated dibit
//   sym_sof      in   marks the first dibit of a frame
//   frame_valid  out  frame_data holds a complete frame
//   frame_data   out  assembled frame, dibit i in bits [2i+1:2i]
//   frame_ready  in   consumer accepts frame_data when frame_valid=1
//   busy         out  FSM not in IDLE
//   err_runt     out  1-cycle pulse: partial frame aborted (restart or timeout)
//   err_overflow out  1-cycle pulse: symbol dropped while in FULL
//   frame_cnt    out  delivered frame count (handshakes), wraps at 255
//
// SYMS_PER_FRAME must be at least 2. GAP_TIMEOUT = 0 disables the timeout.
// ---------------------------------------------------------------------------
module qpsk_frame_deserializer #(
  parameter  int SYMS_PER_FRAME = 14,
  parameter  int GAP_TIMEOUT    = 8,
  localparam int FW             = 2 * SYMS_PER_FRAME
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sym_valid,
  input  logic [1:0]    sym_data,
  input  logic          sym_sof,
  output logic          frame_valid,
  output logic [FW-1:0] frame_data,
  input  logic          frame_ready,
  output logic          busy,
  output logic          err_runt,
  output logic          err_overflow,
  output logic [7:0]    frame_cnt
);

  localparam int IW = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1;
  localparam int GW = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] sym_idx_q;
  logic [GW-1:0] gap_cnt_q;
  logic [FW-1:0] col_q;
  logic [FW-1:0] out_q;
  logic          frame_valid_q;
  logic          err_runt_q;
  logic          err_overflow_q;
  logic [7:0]    frame_cnt_q;

  logic          hs_s;
  logic          last_sym_s;
  logic [GW-1:0] gap_inc_s;
  logic [IW:0]   bit_pos_s;
  logic [FW-1:0] col_ins_d;

  assign hs_s       = frame_valid_q & frame_ready;
  assign last_sym_s = (sym_idx_q == IW'(SYMS_PER_FRAME - 1));
  assign gap_inc_s  = gap_cnt_q + GW'(1);
  assign bit_pos_s  = {sym_idx_q, 1'b0};

  // Collect register with the incoming dibit written at the current index;
  // used both for ordinary collection and for the completing symbol.
  always_comb begin
    col_ins_d = col_q;
    col_ins_d[bit_pos_s +: 2] = sym_data;
  end

  // Frame assembly FSM with registered outputs and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sym_idx_q      <= '0;
      gap_cnt_q      <= '0;
      col_q          <= '0;
      out_q          <= '0;
      frame_valid_q  <= 1'b0;
      err_runt_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      frame_cnt_q    <= 8'd0;
    end else begin
      err_runt_q     <= 1'b0;
      err_overflow_q <= 1'b0;

      // Output drains on handshake; a frame loaded below in the same cycle
      // overrides this and keeps frame_valid high.
      if (hs_s) begin
        frame_cnt_q   <= frame_cnt_q + 8'd1;
        frame_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // Hunting: only a start-of-frame dibit opens a frame.
          if (sym_valid && sym_sof) begin
            col_q[1:0] <= sym_data;
            sym_idx_q  <= IW'(1);
            gap_cnt_q  <= '0;
            state_q    <= COLLECT;
          end
        end

        COLLECT: begin
          if (sym_valid) begin
            gap_cnt_q <= '0;
            if (sym_sof) begin
              // New frame start before completion: drop the partial frame.
              col_q[1:0] <= sym_data;
              sym_idx_q  <= IW'(1);
              err_runt_q <= 1'b1;
            end else if (last_sym_s) begin
              sym_idx_q <= '0;
              if (!frame_valid_q || hs_s) begin
                out_q         <= col_ins_d;
                frame_valid_q <= 1'b1;
                state_q       <= IDLE;
              end else begin
                col_q   <= col_ins_d;
                state_q <= FULL;
              end
            end else begin
              col_q     <= col_ins_d;
              sym_idx_q <= sym_idx_q + IW'(1);
            end
          end else if (GAP_TIMEOUT != 0) begin
            if (gap_inc_s == GW'(GAP_TIMEOUT)) begin
              err_runt_q <= 1'b1;
              gap_cnt_q  <= '0;
              sym_idx_q  <= '0;
              state_q    <= IDLE;
            end else begin
              gap_cnt_q <= gap_inc_s;
            end
          end
        end

        FULL: begin
          // No space anywhere: every arriving symbol is lost and flagged,
          // including one that arrives in the cycle the output frees up.
          if (sym_valid) begin
            err_overflow_q <= 1'b1;
          end
          if (hs_s) begin
            out_q         <= col_q;
            frame_valid_q <= 1'b1;
            state_q       <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign frame_valid  = frame_valid_q;
  assign frame_data   = out_q;
  assign busy         = (state_q != IDLE);
  assign err_runt     = err_runt_q;
  assign err_overflow = err_overflow_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_qpsk_frame_deserializer.sv
module tb_qpsk_frame_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_sof;
  logic        frame_valid;
  logic [27:0] frame_data;
  logic        frame_ready;
  logic        busy;
  logic        err_runt;
  logic        err_overflow;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  logic mon_en = 1'b0;

  qpsk_frame_deserializer #(.SYMS_PER_FRAME(14), .GAP_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_sof      (sym_sof),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_ready  (frame_ready),
    .busy         (busy),
    .err_runt     (err_runt),
    .err_overflow (err_overflow),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Count any error pulse while the burst monitor is enabled.
  always @(negedge clk) begin
    if (mon_en && (err_runt || err_overflow)) err_seen = err_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic sof);
    sym_valid = 1'b1;
    sym_data  = d;
    sym_sof   = sof;
    tick();
    sym_valid = 1'b0;
    sym_sof   = 1'b0;
    sym_data  = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [27:0] rep(input logic [1:0] v);
    logic [27:0] r;
    r = 28'h0;
    for (int i = 0; i < 14; i++) r = (r << 2) | {26'h0, v};
    return r;
  endfunction

  initial begin
    rst = 1'b1; sym_valid = 1'b0; sym_data = 2'b00; sym_sof = 1'b0; frame_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'h0, frame_valid}, 32'h0);
    chk("rst_data", {4'h0, frame_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_errs", {30'h0, err_runt, err_overflow}, 32'h0);
    chk("rst_cnt", {24'h0, frame_cnt}, 32'h0);

    // T1: one contiguous frame 0,1,2,3,...
    frame_ready = 1'b1;
    for (int i = 0; i < 13; i++) send(2'(i % 4), i == 0);
    chk("t1_valid_early", {31'h0, frame_valid}, 32'h0);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    send(2'(13 % 4), 1'b0);
    chk("t1_valid", {31'h0, frame_valid}, 32'h1);
    chk("t1_data", {4'h0, frame_data}, 32'h04E4E4E4);
    idle(1);
    chk("t1_cnt", {24'h0, frame_cnt}, 32'd1);
    chk("t1_valid_drop", {31'h0, frame_valid}, 32'h0);

    // T2: backpressure, second frame held in FULL, overflow drops
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 14; i++) send(2'(i % 4), i == 0);
    chk("t2_a_valid", {31'h0, frame_valid}, 32'h1);
    for (int i = 0; i < 14; i++) send(2'b00, i == 0);
    chk("t2_full_busy", {31'h0, busy}, 32'h1);
    chk("t2_a_held", {4'h0, frame_data}, 32'h04E4E4E4);
    send(2'b11, 1'b0);
    chk("t2_ovf1", {31'h0, err_overflow}, 32'h1);
    send(2'b10, 1'b1);
    chk("t2_ovf2", {31'h0, err_overflow}, 32'h1);
    send(2'b01, 1'b0);
    chk("t2_ovf3", {31'h0, err_overflow}, 32'h1);
    idle(1);
    chk("t2_ovf_end", {31'h0, err_overflow}, 32'h0);
    chk("t2_a_still", {4'h0, frame_data}, 32'h04E4E4E4);
    frame_ready = 1'b1;
    idle(1);
    chk("t2_cnt1", {24'h0, frame_cnt}, 32'd1);
    chk("t2_b_valid", {31'h0, frame_valid}, 32'h1);
    chk("t2_b_data", {4'h0, frame_data}, 32'h0);
    chk("t2_idle", {31'h0, busy}, 32'h0);
    idle(1);
    chk("t2_cnt2", {24'h0, frame_cnt}, 32'd2);
    chk("t2_valid_off", {31'h0, frame_valid}, 32'h0);

    // T3: gap timeout
    do_reset();
    for (int i = 0; i < 6; i++) send(2'b10, i == 0);
    idle(7);
    chk("t3_no_runt_yet", {31'h0, err_runt}, 32'h0);
    chk("t3_busy_yet", {31'h0, busy}, 32'h1);
    idle(1);
    chk("t3_runt", {31'h0, err_runt}, 32'h1);
    chk("t3_busy_off", {31'h0, busy}, 32'h0);
    idle(1);
    chk("t3_runt_pulse", {31'h0, err_runt}, 32'h0);
    chk("t3_no_frame", {31'h0, frame_valid}, 32'h0);

    // T4: restart on sof mid-frame
    do_reset();
    for (int i = 0; i < 7; i++) send(2'b10, i == 0);
    chk("t4_no_runt", {31'h0, err_runt}, 32'h0);
    send(2'b11, 1'b1);
    chk("t4_runt", {31'h0, err_runt}, 32'h1);
    send(2'b11, 1'b0);
    chk("t4_runt_pulse", {31'h0, err_runt}, 32'h0);
    for (int i = 0; i < 11; i++) send(2'b11, 1'b0);
    chk("t4_valid_early", {31'h0, frame_valid}, 32'h0);
    send(2'b11, 1'b0);
    chk("t4_valid", {31'h0, frame_valid}, 32'h1);
    chk("t4_data", {4'h0, frame_data}, 32'h0FFFFFFF);

    // T5: reset mid-frame discards the partial
    do_reset();
    for (int i = 0; i < 10; i++) send(2'b10, i == 0);
    do_reset();
    chk("t5_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 14; i++) send(2'b01, i == 0);
    chk("t5_valid", {31'h0, frame_valid}, 32'h1);
    chk("t5_data", {4'h0, frame_data}, 32'h05555555);
    idle(1);
    chk("t5_cnt", {24'h0, frame_cnt}, 32'd1);

    // T6: hunting then 100 back-to-back frames
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) send(2'(i % 4), 1'b0);
    chk("t6_hunt_busy", {31'h0, busy}, 32'h0);
    chk("t6_hunt_valid", {31'h0, frame_valid}, 32'h0);
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 14; i++) send(2'(f % 4), i == 0);
      chk($sformatf("t6_data_%0d", f), {4'h0, frame_data}, {4'h0, rep(2'(f % 4))});
    end
    idle(1);
    mon_en = 1'b0;
    chk("t6_cnt", {24'h0, frame_cnt}, 32'd100);
    chk("t6_no_err", err_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
